// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the iterative shifter: FSM state encoding and
// direction/mode constants used by the control logic and the shift step.
package seq_shift_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam logic DIR_LEFT     = 1'b1;
    localparam logic MODE_LOGICAL = 1'b1;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result bundle between the control FSM (master) and the shifter (slave).
interface seq_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start_i;
    logic [WIDTH-1:0] in_i;
    logic [SHW-1:0]   shamt_i;
    logic             left_i;
    logic             logical_i;
    logic [WIDTH-1:0] out_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, in_i, shamt_i, left_i, logical_i,
        input  out_o, busy_o, done_o
    );

    modport slave (
        input  start_i, in_i, shamt_i, left_i, logical_i,
        output out_o, busy_o, done_o
    );
endinterface

// File: rtl/seq_shift_unit_shift1.sv
// Combinational single-position shift: left, logical right or arithmetic right.
module shift1_step
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic             left_i,
    input  logic             logical_i,
    output logic [WIDTH-1:0] res_o
);

    always_comb begin
        if (left_i == DIR_LEFT) begin
            res_o = {acc_i[WIDTH-2:0], 1'b0};
        end else if (logical_i == MODE_LOGICAL) begin
            res_o = {1'b0, acc_i[WIDTH-1:1]};
        end else begin
            res_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit position per clock, result held in out until
// the next completion; done pulses for one cycle when out becomes valid.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic             clk,
    input logic             rst_n,
    seq_shift_unit_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             left_q, left_d;
    logic             logical_q, logical_d;
    logic [WIDTH-1:0] step;

    shift1_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .left_i    (left_q),
        .logical_i (logical_q),
        .res_o     (step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            left_q    <= 1'b0;
            logical_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            left_q    <= left_d;
            logical_q <= logical_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        left_d    = left_q;
        logical_d = logical_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    acc_d     = bus.in_i;
                    cnt_d     = bus.shamt_i;
                    left_d    = bus.left_i;
                    logical_d = bus.logical_i;
                    if (bus.shamt_i == '0) begin
                        out_d   = bus.in_i;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = step;
                // cnt saturates at zero; a count of 0 or 1 finishes on this edge
                cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                if (cnt_q <= SHW'(1)) begin
                    out_d   = step;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.out_o  = out_q;
    assign bus.busy_o = (state_q == S_SHIFT);
    assign bus.done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: driver pushes expected results from a
// shift-operator reference model, a monitor pops and compares on every done.
module tb_seq_shift_unit;
    logic clk;
    logic rst_n;

    seq_shift_unit_if #(.WIDTH(32), .SHW(5)) bus ();

    seq_shift_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] val;
        int unsigned edge_no;
        int unsigned sh;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    logic [31:0] last_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input int unsigned sh,
                                              input logic l, input logic lg);
        logic signed [31:0] s;
        s = a;
        if (l) return a << sh;
        if (lg) return a >> sh;
        return s >>> sh;
    endfunction

    // Monitor: sample after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out", bus.out_o, e.val);
                    chk("done_latency", cyc, e.edge_no);
                    chk("busy_cycles", busy_cnt, e.sh);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic rand_ops();
        bus.in_i      = $urandom;
        bus.shamt_i   = 5'($urandom_range(0, 31));
        bus.left_i    = 1'($urandom);
        bus.logical_i = 1'($urandom);
    endtask

    task automatic issue(input logic [31:0] a, input int unsigned sh, input logic l, input logic lg);
        logic [31:0] e;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_done", 32'(bus.done_o), 32'd0);
        chk("out_hold", bus.out_o, last_out);
        bus.start_i   = 1'b1;
        bus.in_i      = a;
        bus.shamt_i   = 5'(sh);
        bus.left_i    = l;
        bus.logical_i = lg;
        e = ref_shift(a, sh, l, lg);
        sb.push_back('{val: e, edge_no: cyc + sh + 1, sh: sh});
        last_out = e;
        @(negedge clk);
        bus.start_i = 1'b0;
        rand_ops();
    endtask

    task automatic wait_done(input logic poke_done);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        if (poke_done) begin
            bus.start_i = 1'b1;
            rand_ops();
        end
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input int unsigned sh, input logic l,
                          input logic lg, input logic poke_busy, input logic poke_done);
        issue(a, sh, l, lg);
        if (poke_busy && sh >= 3) begin
            bus.start_i = 1'b1;
            rand_ops();
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        wait_done(poke_done);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.in_i      = '0;
        bus.shamt_i   = '0;
        bus.left_i    = 1'b0;
        bus.logical_i = 1'b0;
        #1;
        chk("reset_out", bus.out_o, 32'h0);
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_done", 32'(bus.done_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h8000_0000, 3, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(32'h8000_0000, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(32'h8000_0000, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'h4000_0000, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(32'h0000_0001, 31, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(32'hF0F0_1234, 31, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'h1234_5678, 10, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op(32'hDEAD_BEEF, 0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Abort mid-operation with reset.
        issue(32'hCAFE_F00D, 20, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out", bus.out_o, 32'h0);
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_done", 32'(bus.done_o), 32'd0);
        sb.delete();
        last_out = '0;
        repeat (2) @(negedge clk);
        chk("abort_hold_done", 32'(bus.done_o), 32'd0);
        rst_n = 1'b1;
        run_op(32'h0000_00FF, 4, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            run_op($urandom, $urandom_range(0, 31), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
